// File: rtl/sr_zbb_count_unit_pkg.sv
// Shared encodings for the Zbb count unit: op codes and FSM states.
// Optional build macro ZBB_COUNT_EARLY_EXIT_EN is consumed by sr_zbb_count_unit.
package sr_zbb_count_unit_pkg;

  typedef enum logic [1:0] {
    ZBB_CNT_CLZ  = 2'b00,
    ZBB_CNT_CTZ  = 2'b01,
    ZBB_CNT_CPOP = 2'b10,
    ZBB_CNT_RSVD = 2'b11
  } zbbCntOp_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } cntState_t;

endpackage

// File: rtl/sr_zbb_count_unit_chunk.sv
// Combinational per-chunk counter: popcount, leading-zero count and
// non-zero flag of one STEP_BITS-wide slice.
module sr_zbb_chunk_count #(
  parameter int STEP_BITS = 4,
  parameter int CW        = $clog2(STEP_BITS) + 1
) (
  input  logic [STEP_BITS-1:0] chunk,
  output logic [CW-1:0]        popCnt,
  output logic [CW-1:0]        lzCnt,
  output logic                 nonZero
);

  always_comb begin
    popCnt = '0;
    lzCnt  = CW'(STEP_BITS);
    // Scanning upward, the last set bit seen is the most significant one.
    for (int i = 0; i < STEP_BITS; i++) begin
      popCnt = popCnt + CW'(chunk[i]);
      if (chunk[i]) lzCnt = CW'(STEP_BITS - 1 - i);
    end
    nonZero = |chunk;
  end

endmodule

// File: rtl/sr_zbb_count_unit.sv
// Iterative clz/ctz/cpop unit scanning STEP_BITS bits per cycle.
// Define ZBB_COUNT_EARLY_EXIT_EN to finish clz/ctz right after the first non-zero chunk.
module sr_zbb_count_unit
  import sr_zbb_count_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int STEP_BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] operand,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int NCHUNK = XLEN / STEP_BITS;
  localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int AW     = $clog2(XLEN) + 1;
  localparam int CW     = $clog2(STEP_BITS) + 1;

  cntState_t       state, stateNext;
  zbbCntOp_t       opReg, opNext;
  logic [XLEN-1:0] shiftReg, shiftNext;
  logic [XLEN-1:0] resultReg, resultNext;
  logic [AW-1:0]   acc, accNext;
  logic            found, foundNext;
  logic [CNTW-1:0] chunkCnt, cntNext;

  logic [XLEN-1:0] revOperand;
  logic [CW-1:0]   popCnt, lzCnt;
  logic            nonZero;
  logic            lastChunk;
  logic            runEnd;

  // ctz becomes clz of the bit-reversed operand, so one scan path serves both.
  always_comb begin
    revOperand = '0;
    for (int i = 0; i < XLEN; i++) revOperand[i] = operand[XLEN-1-i];
  end

  sr_zbb_chunk_count #(.STEP_BITS(STEP_BITS), .CW(CW)) uChunk (
    .chunk   (shiftReg[XLEN-1 -: STEP_BITS]),
    .popCnt  (popCnt),
    .lzCnt   (lzCnt),
    .nonZero (nonZero)
  );

  assign lastChunk = (chunkCnt == CNTW'(NCHUNK - 1));

  always_comb begin
    stateNext  = state;
    opNext     = opReg;
    shiftNext  = shiftReg;
    resultNext = resultReg;
    accNext    = acc;
    foundNext  = found;
    cntNext    = chunkCnt;
    runEnd     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && (op != ZBB_CNT_RSVD)) begin
          stateNext = ST_RUN;
          opNext    = zbbCntOp_t'(op);
          shiftNext = (op == ZBB_CNT_CTZ) ? revOperand : operand;
          accNext   = '0;
          foundNext = 1'b0;
          cntNext   = '0;
        end
      end
      ST_RUN: begin
        shiftNext = shiftReg << STEP_BITS;
        cntNext   = chunkCnt + 1'b1;
        if (opReg == ZBB_CNT_CPOP) begin
          accNext = acc + AW'(popCnt);
        end else if (!found) begin
          accNext   = acc + AW'(lzCnt);
          foundNext = nonZero;
        end
`ifdef ZBB_COUNT_EARLY_EXIT_EN
        runEnd = lastChunk || ((opReg != ZBB_CNT_CPOP) && !found && nonZero);
`else
        runEnd = lastChunk;
`endif
        if (runEnd) begin
          stateNext  = ST_DONE;
          resultNext = XLEN'(accNext);
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      opReg     <= ZBB_CNT_CLZ;
      shiftReg  <= '0;
      resultReg <= '0;
      acc       <= '0;
      found     <= 1'b0;
      chunkCnt  <= '0;
    end else begin
      state     <= stateNext;
      opReg     <= opNext;
      shiftReg  <= shiftNext;
      resultReg <= resultNext;
      acc       <= accNext;
      found     <= foundNext;
      chunkCnt  <= cntNext;
    end
  end

  assign busy   = (state != ST_IDLE);
  assign done   = (state == ST_DONE);
  assign result = resultReg;

endmodule
